// File: rtl/ena_scheduler_pkg.sv
// Shared types and helpers for ena_scheduler: FSM state encoding, LFSR tap
// constants per width, and the rotating first-set-bit grant and popcount helpers.
package ena_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_FIRE,
        S_SETTLE,
        S_DONE,
        S_DEADLOCK
    } ena_sched_state_t;

    // Helpers work on a fixed maximum width; callers zero-extend narrower vectors.
    localparam int ENA_MAX_W = 64;
    localparam int IDX_W     = 6;

    localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            8:       return LFSR_TAPS_8;
            16:      return LFSR_TAPS_16;
            32:      return LFSR_TAPS_32;
            default: return (32'h1 << (w - 1)) | 32'h1;
        endcase
    endfunction

    // Bits above the caller's width are zero, so wrapping at ENA_MAX_W matches
    // wrapping at the caller's width.
    function automatic logic [ENA_MAX_W-1:0] rr_pick(input logic [ENA_MAX_W-1:0] cand,
                                                     input logic [IDX_W-1:0] start);
        logic [ENA_MAX_W-1:0] grant;
        logic [IDX_W-1:0]     idx;
        logic                 found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < ENA_MAX_W; k++) begin
            idx = start + IDX_W'(k);
            if (!found && cand[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

    function automatic logic [IDX_W:0] popcount(input logic [ENA_MAX_W-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int k = 0; k < ENA_MAX_W; k++) begin
            c = c + {{IDX_W{1'b0}}, v[k]};
        end
        return c;
    endfunction

endpackage

// File: rtl/ena_scheduler_lfsr.sv
// lfsr_prng: right-shifting Galois LFSR that steps once per cycle while adv is high.
module lfsr_prng
    import ena_sched_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] SEED = W'(16'hACE1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    output logic [W-1:0] q
);

    // Top tap bit is always set, so a non-zero state can never shift to zero.
    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (adv) begin
            q_d = q_q[0] ? ((q_q >> 1) ^ TAPS) : (q_q >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ena_scheduler.sv
// ena_scheduler: fires pseudo-randomly chosen excited signals of a clocked circuit model,
// one PICK/FIRE/SETTLE step at a time. Define ENA_SCHED_CONCURRENT_EN to allow multi-fire steps.
module ena_scheduler
    import ena_sched_pkg::*;
#(
    parameter int                N_ENA      = 8,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter int                MAX_EVENTS = 1024,
    parameter int                CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [N_ENA-1:0] excited,
    input  logic [N_ENA-1:0] mask,
    output logic [N_ENA-1:0] ena,
    output logic             busy,
    output logic             deadlock,
    output logic             done,
    output logic [CNT_W-1:0] events
);

    localparam int               SEL_W   = (N_ENA > 1) ? $clog2(N_ENA) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_EVENTS);

    ena_sched_state_t     state_q, state_d;
    logic [N_ENA-1:0]     ena_q, ena_d;
    logic [CNT_W-1:0]     events_q, events_d;
    logic [LFSR_W-1:0]    lfsr_q;
    logic                 lfsr_adv;
    logic [N_ENA-1:0]     cand;
    logic [N_ENA-1:0]     grant;
    logic [ENA_MAX_W-1:0] cand_ext;
    logic [ENA_MAX_W-1:0] rr_grant_ext;
    logic [ENA_MAX_W-1:0] grant_ext;
    logic [SEL_W-1:0]     sel;
    logic [CNT_W-1:0]     inc;
    logic [CNT_W:0]       sum;
    logic                 run_complete;
    logic                 unused_bits;

    lfsr_prng #(
        .W    (LFSR_W),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (lfsr_adv),
        .q     (lfsr_q)
    );

    assign cand = excited & mask;

    // Rotating start index from the LFSR, folded back into range for non-power-of-two widths.
    always_comb begin
        cand_ext              = '0;
        cand_ext[N_ENA-1:0]   = cand;
        sel                   = lfsr_q[SEL_W-1:0];
        if (32'(sel) >= 32'(N_ENA)) begin
            sel = sel - SEL_W'(N_ENA);
        end
        rr_grant_ext = rr_pick(cand_ext, IDX_W'(sel));
    end

`ifdef ENA_SCHED_CONCURRENT_EN
    localparam int REP = N_ENA / LFSR_W + 1;

    logic [REP*LFSR_W-1:0] lfsr_rep;
    logic [N_ENA-1:0]      mix;

    // An empty random subset falls back to a single grant so every step fires something.
    assign lfsr_rep     = {REP{lfsr_q}};
    assign mix          = cand & lfsr_rep[N_ENA-1:0];
    assign grant        = (mix != '0) ? mix : rr_grant_ext[N_ENA-1:0];
    assign run_complete = (MAX_EVENTS != 0) && (events_q >= MAX_CNT);
    assign unused_bits  = ^{lfsr_q, rr_grant_ext, lfsr_rep};
`else
    assign grant        = rr_grant_ext[N_ENA-1:0];
    assign run_complete = (MAX_EVENTS != 0) && (events_q == MAX_CNT);
    assign unused_bits  = ^{lfsr_q, rr_grant_ext};
`endif

    always_comb begin
        grant_ext            = '0;
        grant_ext[N_ENA-1:0] = grant;
        inc                  = CNT_W'(popcount(grant_ext));
        sum                  = {1'b0, events_q} + {1'b0, inc};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_DEADLOCK: begin
                if (start) state_d = S_PICK;
            end
            S_PICK: begin
                if (stop)              state_d = S_IDLE;
                else if (cand == '0)   state_d = S_DEADLOCK;
                else                   state_d = S_FIRE;
            end
            S_FIRE:   state_d = S_SETTLE;
            S_SETTLE: begin
                if (stop)              state_d = S_IDLE;
                else if (run_complete) state_d = S_DONE;
                else                   state_d = S_PICK;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        deadlock = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_PICK, S_FIRE, S_SETTLE: busy     = 1'b1;
            S_DONE:                   done     = 1'b1;
            S_DEADLOCK:               deadlock = 1'b1;
            default: ;
        endcase
    end

    // ena_d defaults to zero, so a grant loaded in PICK is visible for the FIRE cycle only.
    always_comb begin
        ena_d    = '0;
        events_d = events_q;
        lfsr_adv = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_DEADLOCK: begin
                if (start) events_d = '0;
            end
            S_PICK: begin
                if (!stop && (cand != '0)) begin
                    ena_d    = grant;
                    events_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
                    lfsr_adv = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ena_q    <= '0;
            events_q <= '0;
        end else begin
            ena_q    <= ena_d;
            events_q <= events_d;
        end
    end

    assign ena    = ena_q;
    assign events = events_q;

endmodule

// File: tb/tb_ena_scheduler.sv
// tb_ena_scheduler: directed bench for ena_scheduler with N_ENA=4, MAX_EVENTS=5 and a cycle model.
// Building with ENA_SCHED_CONCURRENT_EN switches the model and the extra checks to multi-fire mode.
module tb_ena_scheduler;

    localparam int          N     = 4;
    localparam int          MAXEV = 5;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         start    = 1'b0;
    logic         stop     = 1'b0;
    logic [N-1:0] excited  = '0;
    logic [N-1:0] mask     = '0;
    logic [N-1:0] ena;
    logic         busy;
    logic         deadlock;
    logic         done;
    logic [15:0]  events;

    int vectors     = 0;
    int miscompares = 0;

    // Grants expected from SEED with excited=mask=4'hF, worked out by hand from the LFSR sequence
    // ACE1 -> E270 -> 7138 -> 389C -> 1C4E (start index = low two bits).
    logic [N-1:0] expSeq [5] = '{4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0100};

    always #5 clk = ~clk;

    ena_scheduler #(
        .N_ENA      (N),
        .LFSR_W     (16),
        .SEED       (SEED),
        .MAX_EVENTS (MAXEV),
        .CNT_W      (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .excited  (excited),
        .mask     (mask),
        .ena      (ena),
        .busy     (busy),
        .deadlock (deadlock),
        .done     (done),
        .events   (events)
    );

    // Reference model: the scheduler's run/step rules expressed procedurally.
    typedef enum int {M_IDLE, M_PICK, M_FIRE, M_SETTLE, M_DONE, M_DEAD} phase_t;

    phase_t       mPhase     = M_IDLE;
    logic [15:0]  mLfsr      = SEED;
    logic [N-1:0] mGrant     = '0;
    int           mEvents    = 0;
    bit           modelValid = 1'b0;
    logic [N-1:0] expEna     = '0;
    logic         expBusy    = 1'b0;
    logic         expDone    = 1'b0;
    logic         expDead    = 1'b0;
    int           expEvents  = 0;

    function automatic logic [15:0] nextLfsr(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic int countOnes(input logic [N-1:0] v);
        int c = 0;
        for (int k = 0; k < N; k++) c += int'(v[k]);
        return c;
    endfunction

    function automatic logic [N-1:0] pickModel(input logic [N-1:0] cand, input logic [15:0] l);
        logic [N-1:0] g;
        int           s;
        g = '0;
`ifdef ENA_SCHED_CONCURRENT_EN
        g = cand & l[N-1:0];
        if (g != '0) return g;
`endif
        s = int'(l) % N;
        for (int k = 0; k < N; k++) begin
            if (cand[(s + k) % N]) begin
                g[(s + k) % N] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic bit runOver(input int ev);
`ifdef ENA_SCHED_CONCURRENT_EN
        return ev >= MAXEV;
`else
        return ev == MAXEV;
`endif
    endfunction

    always @(posedge clk) begin : model
        logic [N-1:0] cand;
        cand = excited & mask;
        if (reset) begin
            mPhase     = M_IDLE;
            mLfsr      = SEED;
            mEvents    = 0;
            mGrant     = '0;
            modelValid = 1'b1;
        end else begin
            case (mPhase)
                M_IDLE, M_DONE, M_DEAD: begin
                    if (start) begin
                        mPhase  = M_PICK;
                        mEvents = 0;
                    end
                end
                M_PICK: begin
                    if (stop) mPhase = M_IDLE;
                    else if (cand == '0) mPhase = M_DEAD;
                    else begin
                        mGrant  = pickModel(cand, mLfsr);
                        mEvents = mEvents + countOnes(mGrant);
                        if (mEvents > 65535) mEvents = 65535;
                        mLfsr   = nextLfsr(mLfsr);
                        mPhase  = M_FIRE;
                    end
                end
                M_FIRE: mPhase = M_SETTLE;
                M_SETTLE: begin
                    if (stop) mPhase = M_IDLE;
                    else if (runOver(mEvents)) mPhase = M_DONE;
                    else mPhase = M_PICK;
                end
                default: mPhase = M_IDLE;
            endcase
        end
        expEna    = (mPhase == M_FIRE) ? mGrant : '0;
        expBusy   = (mPhase == M_PICK) || (mPhase == M_FIRE) || (mPhase == M_SETTLE);
        expDone   = (mPhase == M_DONE);
        expDead   = (mPhase == M_DEAD);
        expEvents = mEvents;
    end

    // Every cycle after the first reset edge, all outputs must match the model.
    always @(negedge clk) begin
        if (modelValid) begin
            vectors++;
            if (ena !== expEna || busy !== expBusy || done !== expDone ||
                deadlock !== expDead || events !== 16'(expEvents)) begin
                miscompares++;
                $display("[TB] FAIL cycle-model t=%0t: got ena=%b busy=%b done=%b deadlock=%b events=%0d, want ena=%b busy=%b done=%b deadlock=%b events=%0d",
                         $time, ena, busy, done, deadlock, events,
                         expEna, expBusy, expDone, expDead, expEvents);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic [N-1:0] ex, input logic [N-1:0] mk);
        @(posedge clk);
        #1;
        start   = st;
        stop    = sp;
        excited = ex;
        mask    = mk;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic waitDone(input string name, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(done), 1);
    endtask

    initial begin
        int           pulseCyc [$];
        logic [N-1:0] pulses   [$];
        int           c1000, c0010, cOther, popSum, multi, n;

        doReset();
        @(negedge clk);
        checkOutput("reset-ena", 32'(ena), 0);
        checkOutput("reset-busy", 32'(busy), 0);
        checkOutput("reset-done", 32'(done), 0);
        checkOutput("reset-deadlock", 32'(deadlock), 0);
        checkOutput("reset-events", 32'(events), 0);

        // Single excited signal: grant lands on cycle 2 after start.
        applyStimulus(1'b1, 1'b0, 4'b0100, 4'hF);
        applyStimulus(1'b0, 1'b0, 4'b0100, 4'hF);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t1-ena", 32'(ena), 32'b0100);
        checkOutput("t1-events", 32'(events), 1);
        checkOutput("t1-busy", 32'(busy), 1);
        waitDone("t1-done", 60);

        // Nothing excited: deadlock two cycles after start, and it stays.
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'hF);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'hF);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t2-deadlock", 32'(deadlock), 1);
        checkOutput("t2-busy", 32'(busy), 0);
        checkOutput("t2-ena", 32'(ena), 0);
        checkOutput("t2-events", 32'(events), 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
        @(negedge clk);
        checkOutput("t2-deadlock-sticky", 32'(deadlock), 1);

        // Full run from a fresh seed.
        doReset();
        applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
        applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
        popSum = 0;
        for (int c = 0; c < 60 && done !== 1'b1; c++) begin
            @(negedge clk);
            if (ena != '0) begin
                pulses.push_back(ena);
                pulseCyc.push_back(c);
                popSum += countOnes(ena);
            end
        end
        checkOutput("t3-done", 32'(done), 1);
        checkOutput("t3-events-vs-pulses", 32'(events), 32'(popSum));
`ifndef ENA_SCHED_CONCURRENT_EN
        checkOutput("t3-pulse-count", 32'(pulses.size()), 5);
        checkOutput("t3-events", 32'(events), 5);
        for (int i = 0; i < pulses.size() && i < 5; i++)
            checkOutput($sformatf("t3-grant%0d", i), 32'(pulses[i]), 32'(expSeq[i]));
        if (pulseCyc.size() > 0) checkOutput("t3-first-pulse-cycle", 32'(pulseCyc[0]), 1);
        for (int i = 1; i < pulseCyc.size(); i++)
            checkOutput($sformatf("t3-spacing%0d", i), 32'(pulseCyc[i] - pulseCyc[i-1]), 3);
`else
        checkOutput("t3-events-reached", 32'(events >= 16'(MAXEV)), 1);
`endif

        // start and stop together: start wins, stop is honoured in the first PICK.
        applyStimulus(1'b1, 1'b1, 4'hF, 4'hF);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'hF);
        @(posedge clk);
        @(negedge clk);
        checkOutput("stop-pick-busy", 32'(busy), 0);
        checkOutput("stop-pick-ena", 32'(ena), 0);
        checkOutput("stop-pick-events", 32'(events), 0);

        // stop raised during FIRE is honoured in SETTLE.
        applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
        applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'hF);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("stop-settle-busy", 32'(busy), 0);
        checkOutput("stop-settle-events", 32'(events != 16'd0), 1);
        applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);

        // Masked signals never fire; both unmasked ones get a fair share over 200 steps.
        c1000 = 0; c0010 = 0; cOther = 0;
        for (int r = 0; r < 40; r++) begin
            applyStimulus(1'b1, 1'b0, 4'hF, 4'b1010);
            applyStimulus(1'b0, 1'b0, 4'hF, 4'b1010);
            n = 0;
            while (done !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
                if (ena == 4'b1000) c1000++;
                else if (ena == 4'b0010) c0010++;
                else if (ena != 4'b0000 && ena != 4'b1010) cOther++;
            end
            checkOutput("t4-run-done", 32'(done), 1);
        end
        checkOutput("t4-masked-fired", 32'(cOther), 0);
`ifndef ENA_SCHED_CONCURRENT_EN
        checkOutput("t4-bit3-share", 32'(c1000 >= 40), 1);
        checkOutput("t4-bit1-share", 32'(c0010 >= 40), 1);
`endif

        // Reset in FIRE clears everything at the next edge and reseeds the LFSR.
        applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
        applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
        n = 0;
        while (ena == '0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t5-reached-fire", 32'(ena != '0), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5-ena", 32'(ena), 0);
        checkOutput("t5-busy", 32'(busy), 0);
        checkOutput("t5-events", 32'(events), 0);
        checkOutput("t5-done", 32'(done), 0);
        checkOutput("t5-deadlock", 32'(deadlock), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
        applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
        @(posedge clk);
        @(negedge clk);
`ifdef ENA_SCHED_CONCURRENT_EN
        checkOutput("t5-reseeded-grant", 32'(ena), 32'b0001);
`else
        checkOutput("t5-reseeded-grant", 32'(ena), 32'b0010);
`endif
        waitDone("t5-done-after", 60);

`ifdef ENA_SCHED_CONCURRENT_EN
        // Multi-fire: some steps fire several signals and events tracks the popcount sum.
        multi = 0;
        for (int r = 0; r < 10; r++) begin
            applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
            applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
            popSum = 0;
            n = 0;
            while (done !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
                popSum += countOnes(ena);
                if (countOnes(ena) > 1) multi++;
            end
            checkOutput("t6-run-done", 32'(done), 1);
            checkOutput("t6-events-sum", 32'(events), 32'(popSum));
        end
        checkOutput("t6-multi-seen", 32'(multi > 0), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: bench did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
